// File: rtl/anim_pkg.sv
// Shared definitions for the LED animation frame sequencer.
//   - state_t        : sequencer states (stopped, running, one-shot finished)
//   - MODE_*         : encodings of the 2-bit mode input (11 behaves as loop)
//   - FRAME_W        : width of the frame index driven to the pattern decoders
package anim_pkg;

  localparam int FRAME_W = 5;

  typedef enum logic [1:0] {
    S_STOP = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LOOP     = 2'b00;
  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

endpackage

// File: rtl/anim_prescaler.sv
// Frame-rate prescaler: counts enabled clocks and pulses tick once per
// frame period of (DIV >> speed) clocks.
//   clk, rst : clock and synchronous active-high reset
//   en       : count enable (sequencer running)
//   clr      : clear the count (has priority over en)
//   speed    : period select, period = DIV >> speed
//   tick     : one-cycle advance request
module anim_prescaler
  import anim_pkg::*;
#(
  parameter int DIV = 12_500_000,
  parameter int CW  = $clog2(DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] speed,
  output logic       tick
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_limit;
  logic          w_at_limit;

  // Terminal count for the selected period; a period that shifts down to
  // zero is treated as one clock so the limit never underflows.
  function automatic logic [CW-1:0] period_limit(input logic [1:0] s);
    int unsigned p;
    p = int'(DIV) >> s;
    if (p == 0) p = 1;
    return CW'(p - 1);
  endfunction

  assign w_limit = period_limit(speed);

  // >= rather than == so that raising the speed while the count is already
  // past the new limit ticks immediately instead of waiting for a wrap.
  assign w_at_limit = (r_cnt >= w_limit);
  assign tick       = en && !clr && w_at_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_at_limit ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/anim_step_seq.sv
// Frame sequencer for the LED animation pattern path. Produces the frame
// index consumed combinationally by the 7-segment pattern decoders.
//   clk, rst  : clock and synchronous active-high reset
//   run       : 1 animates, 0 holds the current frame
//   dir       : 0 up, 1 down; seeds the ping-pong direction
//   mode      : 00 loop, 01 one-shot, 10 ping-pong, 11 loop
//   speed     : frame period = DIV >> speed clocks
//   load      : one-cycle jump request to load_val (clamped to LAST)
//   step      : current frame index (registered)
//   frame_stb : one-cycle pulse in the first cycle a new step is visible
//   done      : sticky one-shot completion flag
module anim_step_seq
  import anim_pkg::*;
#(
  parameter int DIV  = 12_500_000,
  parameter int LAST = 31,
  parameter int CW   = $clog2(DIV)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               dir,
  input  logic [1:0]         mode,
  input  logic [1:0]         speed,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_val,
  output logic [FRAME_W-1:0] step,
  output logic               frame_stb,
  output logic               done
);

  localparam logic [FRAME_W-1:0] LAST_V = FRAME_W'(LAST);
  localparam logic [FRAME_W-1:0] ONE_V  = FRAME_W'(1);

  state_t             r_state, w_state_nxt;
  logic [FRAME_W-1:0] r_step, w_step_nxt;
  logic               r_stb, w_stb_nxt;
  logic               r_done, w_done_nxt;
  logic               r_pp_dir, w_pp_dir_nxt;
  // Remembers whether the previous move was made in ping-pong mode, so that
  // entering ping-pong mid-run reseeds the bounce direction from dir.
  logic               r_was_pp, w_was_pp_nxt;

  logic               w_tick;
  logic               w_pre_en;
  logic               w_pre_clr;
  logic               w_pp_eff;
  logic [FRAME_W-1:0] w_load_clamped;

  assign w_pre_en       = (r_state == S_RUN) && run;
  assign w_pre_clr      = load || !w_pre_en;
  assign w_load_clamped = (load_val > LAST_V) ? LAST_V : load_val;
  assign w_pp_eff       = r_was_pp ? r_pp_dir : dir;

  anim_prescaler #(
    .DIV (DIV),
    .CW  (CW)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (w_pre_en),
    .clr   (w_pre_clr),
    .speed (speed),
    .tick  (w_tick)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_step_nxt   = r_step;
    w_stb_nxt    = 1'b0;
    w_done_nxt   = r_done;
    w_pp_dir_nxt = r_pp_dir;
    w_was_pp_nxt = r_was_pp;

    if (load) begin
      // A jump wins over any tick in the same cycle, so the frame moves once.
      w_step_nxt  = w_load_clamped;
      w_stb_nxt   = 1'b1;
      w_done_nxt  = 1'b0;
      w_state_nxt = run ? S_RUN : S_STOP;
      if (run && (r_state != S_RUN)) begin
        w_pp_dir_nxt = dir;
        w_was_pp_nxt = (mode == MODE_PINGPONG);
      end
    end else begin
      case (r_state)
        S_STOP: begin
          if (run) begin
            w_state_nxt  = S_RUN;
            w_pp_dir_nxt = dir;
            w_was_pp_nxt = (mode == MODE_PINGPONG);
          end
        end
        S_RUN: begin
          if (!run) begin
            w_state_nxt = S_STOP;
          end else if (w_tick) begin
            w_was_pp_nxt = (mode == MODE_PINGPONG);
            case (mode)
              MODE_ONESHOT: begin
                if (dir ? (r_step == '0) : (r_step == LAST_V)) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
                end else begin
                  w_step_nxt = dir ? r_step - 1'b1 : r_step + 1'b1;
                  w_stb_nxt  = 1'b1;
                end
              end
              MODE_PINGPONG: begin
                // Bounce in the same edge as reaching the end test so the
                // end frame is shown for a single period only.
                w_stb_nxt = 1'b1;
                if (!w_pp_eff) begin
                  if (r_step == LAST_V) begin
                    w_pp_dir_nxt = 1'b1;
                    w_step_nxt   = LAST_V - 1'b1;
                  end else begin
                    w_pp_dir_nxt = 1'b0;
                    w_step_nxt   = r_step + 1'b1;
                  end
                end else begin
                  if (r_step == '0) begin
                    w_pp_dir_nxt = 1'b0;
                    w_step_nxt   = ONE_V;
                  end else begin
                    w_pp_dir_nxt = 1'b1;
                    w_step_nxt   = r_step - 1'b1;
                  end
                end
              end
              default: begin
                w_stb_nxt = 1'b1;
                if (!dir) begin
                  w_step_nxt = (r_step == LAST_V) ? '0 : r_step + 1'b1;
                end else begin
                  w_step_nxt = (r_step == '0) ? LAST_V : r_step - 1'b1;
                end
              end
            endcase
          end
        end
        default: begin
          // S_DONE holds until load or rst.
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_STOP;
      r_step   <= '0;
      r_stb    <= 1'b0;
      r_done   <= 1'b0;
      r_pp_dir <= 1'b0;
      r_was_pp <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_step   <= w_step_nxt;
      r_stb    <= w_stb_nxt;
      r_done   <= w_done_nxt;
      r_pp_dir <= w_pp_dir_nxt;
      r_was_pp <= w_was_pp_nxt;
    end
  end

  assign step      = r_step;
  assign frame_stb = r_stb;
  assign done      = r_done;

endmodule

// File: tb/tb_anim_step_seq.sv
module tb_anim_step_seq;

  localparam int DIV  = 4;
  localparam int LAST = 9;

  logic       clk = 1'b0;
  logic       rst, run, dir, load;
  logic [1:0] mode, speed;
  logic [4:0] load_val;
  logic [4:0] step;
  logic       frame_stb, done;

  int cycle    = 0;
  int checks   = 0;
  int failures = 0;

  logic [4:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  anim_step_seq #(.DIV(DIV), .LAST(LAST)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .dir       (dir),
    .mode      (mode),
    .speed     (speed),
    .load      (load),
    .load_val  (load_val),
    .step      (step),
    .frame_stb (frame_stb),
    .done      (done)
  );

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  // Advance until a strobe is observed or the budget runs out.
  task automatic wait_stb(input int maxc, output bit ok, output int at);
    ok = 1'b0;
    at = cycle;
    for (int i = 0; i < maxc; i++) begin
      tick1();
      if (frame_stb === 1'b1) begin
        ok = 1'b1;
        at = cycle;
        break;
      end
    end
    if (!ok) at = cycle;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; dir = 1'b0; mode = 2'b00; speed = 2'b00;
    load = 1'b0; load_val = 5'd0;
    tick1(); tick1();
    checks++;
    if (step !== 5'd0) begin failures++; $display("FAIL reset_step: got %0d want 0", step); end
    checks++;
    if (frame_stb !== 1'b0) begin failures++; $display("FAIL reset_stb: got %b want 0", frame_stb); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
    tick1(); tick1();
    checks++;
    if (step !== 5'd0 || frame_stb !== 1'b0) begin
      failures++; $display("FAIL idle_hold: step=%0d stb=%b want step=0 stb=0", step, frame_stb);
    end
  endtask

  task automatic test_loop();
    bit ok; int at, t_prev, gap; logic [4:0] e;
    for (int v = 1; v <= 9; v++) exp_q.push_back(5'(v));
    exp_q.push_back(5'd0);
    exp_q.push_back(5'd1);
    run = 1'b1;
    t_prev = cycle; gap = 5;
    while (exp_q.size() > 0) begin
      wait_stb(12, ok, at);
      e = exp_q.pop_front();
      checks++;
      if (!ok || step !== e || (at - t_prev) != gap) begin
        failures++;
        $display("FAIL loop_seq: step=%0d gap=%0d strobe=%0d want step=%0d gap=%0d", step, at - t_prev, ok, e, gap);
      end
      t_prev = at; gap = 4;
    end
    // Reset in the middle of the animation while run stays high.
    rst = 1'b1;
    tick1();
    checks++;
    if (step !== 5'd0 || frame_stb !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mid_reset: step=%0d stb=%b done=%b want 0 0 0", step, frame_stb, done);
    end
    rst = 1'b0;
    t_prev = cycle;
    wait_stb(12, ok, at);
    checks++;
    if (!ok || step !== 5'd1 || (at - t_prev) != 5) begin
      failures++; $display("FAIL post_reset_first: step=%0d gap=%0d want step=1 gap=5", step, at - t_prev);
    end
    run = 1'b0;
    tick1();
  endtask

  task automatic test_oneshot();
    bit ok, seen; int at, t_prev; logic [4:0] e;
    mode = 2'b01; dir = 1'b1; load_val = 5'd3; load = 1'b1; run = 1'b1;
    tick1();
    load = 1'b0;
    checks++;
    if (step !== 5'd3 || frame_stb !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL oneshot_load: step=%0d stb=%b done=%b want 3 1 0", step, frame_stb, done);
    end
    exp_q.push_back(5'd2); exp_q.push_back(5'd1); exp_q.push_back(5'd0);
    t_prev = cycle;
    while (exp_q.size() > 0) begin
      wait_stb(12, ok, at);
      e = exp_q.pop_front();
      checks++;
      if (!ok || step !== e || (at - t_prev) != 4) begin
        failures++; $display("FAIL oneshot_seq: step=%0d gap=%0d want step=%0d gap=4", step, at - t_prev, e);
      end
      t_prev = at;
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin tick1(); if (frame_stb) seen = 1'b1; end
    checks++;
    if (done !== 1'b0 || seen) begin
      failures++; $display("FAIL oneshot_early_done: done=%b strobe=%b want 0 0", done, seen);
    end
    tick1();
    checks++;
    if (done !== 1'b1 || step !== 5'd0 || frame_stb !== 1'b0) begin
      failures++; $display("FAIL oneshot_done: done=%b step=%0d stb=%b want 1 0 0", done, step, frame_stb);
    end
    seen = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin tick1(); if (frame_stb) seen = 1'b1; end
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin tick1(); if (frame_stb) seen = 1'b1; end
    checks++;
    if (done !== 1'b1 || step !== 5'd0 || seen) begin
      failures++; $display("FAIL done_sticky: done=%b step=%0d strobe=%b want 1 0 0", done, step, seen);
    end
    load_val = 5'd5; load = 1'b1;
    tick1();
    load = 1'b0;
    checks++;
    if (step !== 5'd5 || done !== 1'b0 || frame_stb !== 1'b1) begin
      failures++; $display("FAIL done_reload: step=%0d done=%b stb=%b want 5 0 1", step, done, frame_stb);
    end
    t_prev = cycle;
    wait_stb(12, ok, at);
    checks++;
    if (!ok || step !== 5'd4 || (at - t_prev) != 4) begin
      failures++; $display("FAIL reload_resume: step=%0d gap=%0d want step=4 gap=4", step, at - t_prev);
    end
    run = 1'b0;
    tick1();
  endtask

  task automatic test_pingpong();
    bit ok; int at, t_prev, gap; logic [4:0] e;
    mode = 2'b10; dir = 1'b0; load_val = 5'd7; load = 1'b1;
    tick1();
    load = 1'b0;
    checks++;
    if (step !== 5'd7 || frame_stb !== 1'b1) begin
      failures++; $display("FAIL pp_load: step=%0d stb=%b want 7 1", step, frame_stb);
    end
    tick1();
    exp_q.push_back(5'd8); exp_q.push_back(5'd9);
    for (int v = 8; v >= 0; v--) exp_q.push_back(5'(v));
    exp_q.push_back(5'd1);
    run = 1'b1;
    t_prev = cycle; gap = 5;
    while (exp_q.size() > 0) begin
      wait_stb(12, ok, at);
      e = exp_q.pop_front();
      checks++;
      if (!ok || step !== e || (at - t_prev) != gap) begin
        failures++; $display("FAIL pp_seq: step=%0d gap=%0d want step=%0d gap=%0d", step, at - t_prev, e, gap);
      end
      t_prev = at; gap = 4;
      dir = 1'b1;  // bounce direction is owned by the sequencer once running
    end
    run = 1'b0; dir = 1'b0;
    tick1();
  endtask

  task automatic test_speed();
    bit ok; int at, t_prev, gap; logic [4:0] e;
    mode = 2'b00; dir = 1'b0; speed = 2'b10;
    for (int v = 2; v <= 5; v++) exp_q.push_back(5'(v));
    run = 1'b1;
    t_prev = cycle; gap = 2;
    while (exp_q.size() > 0) begin
      wait_stb(12, ok, at);
      e = exp_q.pop_front();
      checks++;
      if (!ok || step !== e || (at - t_prev) != gap) begin
        failures++; $display("FAIL fast_seq: step=%0d gap=%0d want step=%0d gap=%0d", step, at - t_prev, e, gap);
      end
      t_prev = at; gap = 1;
    end
    speed = 2'b00;
    exp_q.push_back(5'd6); exp_q.push_back(5'd7);
    while (exp_q.size() > 0) begin
      wait_stb(12, ok, at);
      e = exp_q.pop_front();
      checks++;
      if (!ok || step !== e || (at - t_prev) != 4) begin
        failures++; $display("FAIL slow_seq: step=%0d gap=%0d want step=%0d gap=4", step, at - t_prev, e);
      end
      t_prev = at;
    end
    tick1(); tick1();
    speed = 2'b01;  // count already past the new limit
    exp_q.push_back(5'd8); exp_q.push_back(5'd9);
    gap = 3;
    while (exp_q.size() > 0) begin
      wait_stb(12, ok, at);
      e = exp_q.pop_front();
      checks++;
      if (!ok || step !== e || (at - t_prev) != gap) begin
        failures++; $display("FAIL speedup_seq: step=%0d gap=%0d want step=%0d gap=%0d", step, at - t_prev, e, gap);
      end
      t_prev = at; gap = 2;
    end
    run = 1'b0; speed = 2'b00;
    tick1();
  endtask

  task automatic test_load_tick();
    bit ok, seen; int at, t_prev; logic [4:0] e;
    exp_q.push_back(5'd0);
    run = 1'b1;
    t_prev = cycle;
    wait_stb(12, ok, at);
    e = exp_q.pop_front();
    checks++;
    if (!ok || step !== e || (at - t_prev) != 5) begin
      failures++; $display("FAIL wrap_to_zero: step=%0d gap=%0d want step=%0d gap=5", step, at - t_prev, e);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin tick1(); if (frame_stb) seen = 1'b1; end
    load_val = 5'd20; load = 1'b1;
    exp_q.push_back(5'd9);
    tick1();
    load = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (step !== e || frame_stb !== 1'b1 || seen) begin
      failures++; $display("FAIL load_on_tick: step=%0d stb=%b early=%b want step=%0d stb=1 early=0", step, frame_stb, seen, e);
    end
    t_prev = cycle;
    tick1();
    checks++;
    if (step !== 5'd9 || frame_stb !== 1'b0) begin
      failures++; $display("FAIL load_single_move: step=%0d stb=%b want 9 0", step, frame_stb);
    end
    exp_q.push_back(5'd0);
    wait_stb(12, ok, at);
    e = exp_q.pop_front();
    checks++;
    if (!ok || step !== e || (at - t_prev) != 4) begin
      failures++; $display("FAIL after_load_period: step=%0d gap=%0d want step=%0d gap=4", step, at - t_prev, e);
    end
  endtask

  task automatic test_pause();
    bit ok, seen; int at, t_prev;
    tick1(); tick1();
    run = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin tick1(); if (frame_stb) seen = 1'b1; end
    checks++;
    if (step !== 5'd0 || seen) begin
      failures++; $display("FAIL pause_hold: step=%0d strobe=%b want 0 0", step, seen);
    end
    run = 1'b1;
    t_prev = cycle;
    wait_stb(12, ok, at);
    checks++;
    if (!ok || step !== 5'd1 || (at - t_prev) != 5) begin
      failures++; $display("FAIL pause_resume: step=%0d gap=%0d want step=1 gap=5", step, at - t_prev);
    end
    run = 1'b0;
    tick1();
    load_val = 5'd4; load = 1'b1;
    tick1();
    load = 1'b0;
    checks++;
    if (step !== 5'd4 || frame_stb !== 1'b1) begin
      failures++; $display("FAIL stopped_load: step=%0d stb=%b want 4 1", step, frame_stb);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin tick1(); if (frame_stb) seen = 1'b1; end
    checks++;
    if (step !== 5'd4 || seen) begin
      failures++; $display("FAIL stopped_stays: step=%0d strobe=%b want 4 0", step, seen);
    end
    load = 1'b1;
    tick1();
    load = 1'b0;
    checks++;
    if (step !== 5'd4 || frame_stb !== 1'b1) begin
      failures++; $display("FAIL same_value_load: step=%0d stb=%b want 4 1", step, frame_stb);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_loop();
    test_oneshot();
    test_pingpong();
    test_speed();
    test_load_tick();
    test_pause();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
